// File: rtl/vend_pkg.sv
// Shared vend definitions: coffee_select encodings, arbiter FSM states and
// recipe-to-brew-length helpers used by both the vend controllers and the arbiter.
package vend_pkg;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_PC   = 3'd1;
    localparam logic [2:0] SEL_HC   = 3'd2;
    localparam logic [2:0] SEL_CC   = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BREW = 2'd1,
        ST_DONE = 2'd2,
        ST_REST = 2'd3
    } state_t;

    function automatic logic sel_valid(input logic [2:0] sel);
        return (sel == SEL_PC) || (sel == SEL_HC) || (sel == SEL_CC);
    endfunction

    // Invalid selects map to zero; callers must gate on sel_valid first.
    function automatic int recipe_cycles(input logic [2:0] sel, input int pc,
                                         input int hc, input int cc);
        case (sel)
            SEL_PC:  return pc;
            SEL_HC:  return hc;
            SEL_CC:  return cc;
            default: return 0;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/vend_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around NUM_PORTS.
module vend_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic                 valid,
    output logic [PW-1:0]        idx
);

    int j;

    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int off = NUM_PORTS - 1; off >= 0; off--) begin
            j = (int'(ptr) + off) % NUM_PORTS;
            if (req[j]) begin
                valid = 1'b1;
                idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter sharing one brew unit among NUM_PORTS vend controllers.
// Optional CUP_COUNT_EN adds saturating per-recipe cup counters.
module vend_dispense_arbiter
    import vend_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PC_CYCLES = 8,
    parameter int HC_CYCLES = 12,
    parameter int CC_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         req_dispense,
    input  logic [3*NUM_PORTS-1:0]       req_select,
    output logic [NUM_PORTS-1:0]         dispense_done,
    output logic                         brew_valve,
    output logic [2:0]                   brew_select,
    output logic [$clog2(NUM_PORTS)-1:0] grant_port,
    output logic                         busy,
`ifdef CUP_COUNT_EN
    output logic [15:0]                  cnt_pc,
    output logic [15:0]                  cnt_hc,
    output logic [15:0]                  cnt_cc,
`endif
    output logic                         sel_err
);

    localparam int PW      = $clog2(NUM_PORTS);
    localparam int MAX_CYC = max3(PC_CYCLES, HC_CYCLES, CC_CYCLES);
    localparam int TW      = $clog2(MAX_CYC) + 1;

    state_t                state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic [PW-1:0]         owner, owner_n;
    logic [PW-1:0]         rr_ptr, rr_n;
    logic                  valve_n;
    logic [2:0]            bsel_n;
    logic [NUM_PORTS-1:0]  done_n;
    logic                  err_n;
    logic                  busy_n;

    logic                  pick_vld;
    logic [PW-1:0]         pick_idx;
    logic [2:0]            pick_sel;

    vend_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_pick (
        .req   (req_dispense),
        .ptr   (rr_ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign pick_sel   = req_select[3*int'(pick_idx) +: 3];
    assign grant_port = owner;

    always_comb begin
        state_n = state;
        timer_n = timer;
        owner_n = owner;
        rr_n    = rr_ptr;
        valve_n = 1'b0;
        bsel_n  = SEL_NONE;
        done_n  = '0;
        err_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_n = pick_idx;
                    if (sel_valid(pick_sel)) begin
                        state_n = ST_BREW;
                        timer_n = TW'(recipe_cycles(pick_sel, PC_CYCLES, HC_CYCLES,
                                                    CC_CYCLES) - 1);
                        valve_n = 1'b1;
                        bsel_n  = pick_sel;
                    end else begin
                        // Bad recipe: skip brewing but still release the vend.
                        state_n          = ST_DONE;
                        err_n            = 1'b1;
                        done_n[pick_idx] = 1'b1;
                    end
                end
            end
            ST_BREW: begin
                if (!req_dispense[owner]) begin
                    state_n = ST_REST;
                end else if (timer == '0) begin
                    state_n       = ST_DONE;
                    done_n[owner] = 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                    valve_n = 1'b1;
                    bsel_n  = brew_select;
                end
            end
            ST_DONE: begin
                state_n = ST_REST;
                rr_n    = (owner == PW'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
            end
            ST_REST: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            timer         <= '0;
            owner         <= '0;
            rr_ptr        <= '0;
            brew_valve    <= 1'b0;
            brew_select   <= SEL_NONE;
            dispense_done <= '0;
            sel_err       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            owner         <= owner_n;
            rr_ptr        <= rr_n;
            brew_valve    <= valve_n;
            brew_select   <= bsel_n;
            dispense_done <= done_n;
            sel_err       <= err_n;
            busy          <= busy_n;
        end
    end

`ifdef CUP_COUNT_EN
    logic [2:0] recipe;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only completed brews reach DONE with a valid recipe; aborts bypass DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            recipe <= SEL_NONE;
            cnt_pc <= '0;
            cnt_hc <= '0;
            cnt_cc <= '0;
        end else begin
            if (state == ST_IDLE && pick_vld) recipe <= pick_sel;
            if (state == ST_DONE) begin
                case (recipe)
                    SEL_PC:  cnt_pc <= sat_inc(cnt_pc);
                    SEL_HC:  cnt_hc <= sat_inc(cnt_hc);
                    SEL_CC:  cnt_cc <= sat_inc(cnt_cc);
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Directed self-checking bench for vend_dispense_arbiter (4 ports, 8/12/16 cycles).
module tb_vend_dispense_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_dispense;
    logic [11:0] req_select;
    logic [3:0]  dispense_done;
    logic        brew_valve;
    logic [2:0]  brew_select;
    logic [1:0]  grant_port;
    logic        busy;
    logic        sel_err;
`ifdef CUP_COUNT_EN
    logic [15:0] cnt_pc, cnt_hc, cnt_cc;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vend_dispense_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req_dispense  (req_dispense),
        .req_select    (req_select),
        .dispense_done (dispense_done),
        .brew_valve    (brew_valve),
        .brew_select   (brew_select),
        .grant_port    (grant_port),
        .busy          (busy),
`ifdef CUP_COUNT_EN
        .cnt_pc        (cnt_pc),
        .cnt_hc        (cnt_hc),
        .cnt_cc        (cnt_cc),
`endif
        .sel_err       (sel_err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int port, input logic [2:0] sel);
        req_select[3*port +: 3] = sel;
    endtask

    // One full service from IDLE: grant, count valve cycles, done pulse, REST, IDLE.
    // drop: 0 keep request, 1 drop right after done, 2 drop once back in IDLE.
    task automatic serve(input int port, input int cyc, input logic [2:0] sel, input int drop);
        int n;
        bit seen;
        tick();
        check("grant_port", grant_port, port);
        check("valve_on", brew_valve, 1);
        check("brew_select", brew_select, sel);
        check("busy_brew", busy, 1);
        n    = 1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (dispense_done != 0) seen = 1;
            else if (brew_valve) n++;
        end
        check("done_seen", seen, 1);
        check("valve_cycles", n, cyc);
        check("done_mask", dispense_done, 1 << port);
        check("valve_off_done", brew_valve, 0);
        if (drop == 1) req_dispense[port] = 1'b0;
        tick();
        check("done_clear", dispense_done, 0);
        check("busy_rest", busy, 1);
        tick();
        check("busy_idle", busy, 0);
        if (drop == 2) req_dispense[port] = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        req_dispense = '0;
        req_select   = '0;

        // Reset state
        tick();
        tick();
        check("rst_done", dispense_done, 0);
        check("rst_valve", brew_valve, 0);
        check("rst_select", brew_select, 0);
        check("rst_grant", grant_port, 0);
        check("rst_busy", busy, 0);
        check("rst_selerr", sel_err, 0);
        reset = 1'b1;

        // 1: port0 plain coffee
        set_sel(0, 3'd1);
        req_dispense = 4'b0001;
        serve(0, 8, 3'd1, 1);

        // 2: ports 1 and 3 together from pointer 0, hazelnut
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_sel(1, 3'd2);
        set_sel(3, 3'd2);
        req_dispense = 4'b1010;
        serve(1, 12, 3'd2, 1);
        serve(3, 12, 3'd2, 1);

        // 3: all ports continuously requesting
        for (int p = 0; p < 4; p++) set_sel(p, 3'd1);
        req_dispense = 4'b1111;
        serve(0, 8, 3'd1, 0);
        serve(1, 8, 3'd1, 0);
        serve(2, 8, 3'd1, 0);
        serve(3, 8, 3'd1, 0);
        serve(0, 8, 3'd1, 0);
        req_dispense = 4'b0000;

        // 4: owner holds request through DONE and REST; no second brew
        tick();
        req_dispense = 4'b0100;
        serve(2, 8, 3'd1, 2);
        tick();
        check("lag_valve", brew_valve, 0);
        check("lag_busy", busy, 0);
        tick();
        check("lag_valve2", brew_valve, 0);
        check("lag_done", dispense_done, 0);

        // 5: invalid select on port2
        set_sel(2, 3'd0);
        req_dispense = 4'b0100;
        tick();
        check("inv_selerr", sel_err, 1);
        check("inv_done", dispense_done, 4'b0100);
        check("inv_valve", brew_valve, 0);
        check("inv_grant", grant_port, 2);
        req_dispense = 4'b0000;
        tick();
        check("inv_selerr_clr", sel_err, 0);
        check("inv_done_clr", dispense_done, 0);
        check("inv_valve2", brew_valve, 0);
        tick();
        check("inv_busy_idle", busy, 0);

        // 6: reset during the fifth cycle of a coconut brew on port3
        set_sel(3, 3'd3);
        set_sel(1, 3'd1);
        req_dispense = 4'b1000;
        tick();
        check("cc_grant", grant_port, 3);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("cc_valve_on", brew_valve, 1);
        end
        reset        = 1'b0;
        req_dispense = 4'b1010;
        tick();
        check("rst_cut_valve", brew_valve, 0);
        check("rst_cut_done", dispense_done, 0);
        check("rst_cut_busy", busy, 0);
        check("rst_cut_grant", grant_port, 0);
`ifdef CUP_COUNT_EN
        check("rst_cnt_cc", cnt_cc, 0);
`endif
        reset = 1'b1;
        tick();
        check("restart_grant", grant_port, 1);
        check("restart_valve", brew_valve, 1);
        check("restart_done", dispense_done, 0);
        reset = 1'b0;
        req_dispense = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
